// File: rtl/matrix_frame_fetch_pkg.sv
// Shared definitions for the matrix frame fetcher: register map, STATUS layout, FSM states.
package matrix_frame_fetch_pkg;

  // Slave register indices
  localparam int unsigned REG_FRAME_ADDR = 0;
  localparam int unsigned REG_STATUS     = 1;

  // STATUS bit positions
  localparam int unsigned ST_PENDING = 0;
  localparam int unsigned ST_BUSY    = 1;
  localparam int unsigned ST_ERR     = 2;
  localparam int unsigned ST_ROW_LSB = 5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LATCH,
    S_REQ,
    S_ACK,
    S_PRESENT
  } fetch_state_e;

  // Pack the STATUS word from its fields
  function automatic logic [15:0] status_word(input logic [3:0] row, input logic err,
                                              input logic busy, input logic pending);
    logic [15:0] w;
    w = '0;
    w[ST_PENDING]        = pending;
    w[ST_BUSY]           = busy;
    w[ST_ERR]            = err;
    w[ST_ROW_LSB +: 4]   = row;
    return w;
  endfunction

endpackage

// File: rtl/matrix_frame_fetch_regs.sv
// Wishbone slave register file: FRAME_ADDR (pending page) and read-only STATUS.
// Ports: clk/rst, Wishbone slave (s_*), swap_i clears pending when the fetcher adopts the page,
// status_i is the live STATUS word, pending_addr_o/pending_o expose the queued page.
module matrix_regs
  import matrix_frame_fetch_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned RESET_FRAME = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            s_adr_i,
  input  logic [DATA_WIDTH-1:0] s_dat_i,
  output logic [DATA_WIDTH-1:0] s_dat_o,
  input  logic                  s_we_i,
  input  logic                  s_stb_i,
  input  logic                  s_cyc_i,
  output logic                  s_ack_o,
  input  logic                  swap_i,
  input  logic [15:0]           status_i,
  output logic [DATA_WIDTH-1:0] pending_addr_o,
  output logic                  pending_o
);

  logic                  ack_q;
  logic [DATA_WIDTH-1:0] dat_q;
  logic [DATA_WIDTH-1:0] pending_addr_q;
  logic                  pending_q;
  logic                  req_c;

  assign req_c = s_cyc_i & s_stb_i & ~ack_q;

  // Register access; a write in the swap cycle re-arms pending (set wins over clear)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack_q          <= 1'b0;
      dat_q          <= '0;
      pending_addr_q <= DATA_WIDTH'(RESET_FRAME);
      pending_q      <= 1'b0;
    end else begin
      ack_q <= req_c;
      if (swap_i) pending_q <= 1'b0;
      if (req_c) begin
        if (s_we_i) begin
          if (s_adr_i == 2'(REG_FRAME_ADDR)) begin
            pending_addr_q <= s_dat_i;
            pending_q      <= 1'b1;
          end
        end else begin
          case (s_adr_i)
            2'(REG_FRAME_ADDR): dat_q <= pending_addr_q;
            2'(REG_STATUS):     dat_q <= DATA_WIDTH'(status_i);
            default:            dat_q <= '0;
          endcase
        end
      end
    end
  end

  assign s_ack_o        = ack_q;
  assign s_dat_o        = dat_q;
  assign pending_addr_o = pending_addr_q;
  assign pending_o      = pending_q;

endmodule

// File: rtl/matrix_frame_fetch.sv
// Fetches the active frame from shared RAM (Wishbone master) and streams RGB565 pixels
// row-major to the LED scan driver. Page swaps happen only at frame start.
// Ports: clk/rst, Wishbone slave s_* (FRAME_ADDR/STATUS), Wishbone master m_* (classic reads),
// frame_req start pulse, pixel stream px_data/px_row/px_col/px_last/px_valid/px_ready.
module matrix_frame_fetch
  import matrix_frame_fetch_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH = 16,
  parameter int unsigned DATA_WIDTH    = 16,
  parameter int unsigned COLS          = 20,
  parameter int unsigned ROWS          = 15,
  parameter int unsigned MAX_WAIT      = 8,
  parameter int unsigned RESET_FRAME   = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [1:0]               s_adr_i,
  input  logic [DATA_WIDTH-1:0]    s_dat_i,
  output logic [DATA_WIDTH-1:0]    s_dat_o,
  input  logic                     s_we_i,
  input  logic                     s_stb_i,
  input  logic                     s_cyc_i,
  output logic                     s_ack_o,
  output logic [ADDRESS_WIDTH-1:0] m_adr_o,
  input  logic [DATA_WIDTH-1:0]    m_dat_i,
  output logic                     m_we_o,
  output logic [1:0]               m_sel_o,
  output logic                     m_stb_o,
  output logic                     m_cyc_o,
  input  logic                     m_ack_i,
  output logic [2:0]               m_cti_o,
  input  logic                     frame_req,
  output logic [DATA_WIDTH-1:0]    px_data,
  output logic [3:0]               px_row,
  output logic [4:0]               px_col,
  output logic                     px_last,
  output logic                     px_valid,
  input  logic                     px_ready
);

  localparam int unsigned AW     = ADDRESS_WIDTH;
  localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);

  fetch_state_e            state_q;
  logic [AW-1:0]           active_q;
  logic [AW-1:0]           m_adr_q;
  logic                    m_stb_q;
  logic [3:0]              row_q;
  logic [4:0]              col_q;
  logic [WAIT_W-1:0]       wait_q;
  logic                    err_q;
  logic [DATA_WIDTH-1:0]   px_data_q;
  logic                    px_last_q;
  logic                    px_valid_q;

  logic [DATA_WIDTH-1:0]   pending_addr_w;
  logic                    pending_w;
  logic                    swap_c;
  logic                    last_c;
  logic [AW-1:0]           pix_off_c;
  logic [15:0]             status_c;

  assign swap_c    = (state_q == S_LATCH) & pending_w;
  assign last_c    = (row_q == 4'(ROWS - 1)) && (col_q == 5'(COLS - 1));
  assign pix_off_c = AW'({row_q, col_q, 1'b0});
  assign status_c  = status_word(row_q, err_q, state_q != S_IDLE, pending_w);

  matrix_regs #(
    .DATA_WIDTH  (DATA_WIDTH),
    .RESET_FRAME (RESET_FRAME)
  ) u_regs (
    .clk            (clk),
    .rst            (rst),
    .s_adr_i        (s_adr_i),
    .s_dat_i        (s_dat_i),
    .s_dat_o        (s_dat_o),
    .s_we_i         (s_we_i),
    .s_stb_i        (s_stb_i),
    .s_cyc_i        (s_cyc_i),
    .s_ack_o        (s_ack_o),
    .swap_i         (swap_c),
    .status_i       (status_c),
    .pending_addr_o (pending_addr_w),
    .pending_o      (pending_w)
  );

  // Fetch FSM with master port and pixel stream registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      active_q   <= AW'(RESET_FRAME);
      m_adr_q    <= '0;
      m_stb_q    <= 1'b0;
      row_q      <= '0;
      col_q      <= '0;
      wait_q     <= '0;
      err_q      <= 1'b0;
      px_data_q  <= '0;
      px_last_q  <= 1'b0;
      px_valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (frame_req) state_q <= S_LATCH;
        end
        S_LATCH: begin
          if (pending_w) active_q <= AW'(pending_addr_w);
          row_q   <= '0;
          col_q   <= '0;
          state_q <= S_REQ;
        end
        S_REQ: begin
          m_adr_q <= active_q + pix_off_c;
          m_stb_q <= 1'b1;
          wait_q  <= '0;
          state_q <= S_ACK;
        end
        S_ACK: begin
          if (m_ack_i) begin
            px_data_q  <= m_dat_i;
            m_stb_q    <= 1'b0;
            px_valid_q <= 1'b1;
            px_last_q  <= last_c;
            state_q    <= S_PRESENT;
          end else if (wait_q == WAIT_W'(MAX_WAIT - 1)) begin
            // No ack within MAX_WAIT strobe cycles: emit a black pixel and flag it
            px_data_q  <= '0;
            err_q      <= 1'b1;
            m_stb_q    <= 1'b0;
            px_valid_q <= 1'b1;
            px_last_q  <= last_c;
            state_q    <= S_PRESENT;
          end else begin
            wait_q <= wait_q + 1'b1;
          end
        end
        S_PRESENT: begin
          if (px_ready) begin
            px_valid_q <= 1'b0;
            px_last_q  <= 1'b0;
            if (last_c) begin
              state_q <= S_IDLE;
            end else begin
              if (col_q == 5'(COLS - 1)) begin
                col_q <= '0;
                row_q <= row_q + 1'b1;
              end else begin
                col_q <= col_q + 1'b1;
              end
              state_q <= S_REQ;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign m_adr_o  = m_adr_q;
  assign m_stb_o  = m_stb_q;
  assign m_cyc_o  = m_stb_q;
  assign m_we_o   = 1'b0;
  assign m_sel_o  = 2'b11;
  assign m_cti_o  = 3'b000;
  assign px_data  = px_data_q;
  assign px_row   = row_q;
  assign px_col   = col_q;
  assign px_last  = px_last_q;
  assign px_valid = px_valid_q;

endmodule

// File: tb/tb_matrix_frame_fetch.sv
// Directed bench for matrix_frame_fetch: register access, full frames, page swap timing,
// master timeout, downstream stall and mid-frame reset.
module tb_matrix_frame_fetch;

  localparam int COLS = 20;
  localparam int ROWS = 15;
  localparam int NPIX = COLS * ROWS;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  s_adr_i;
  logic [15:0] s_dat_i;
  logic [15:0] s_dat_o;
  logic        s_we_i, s_stb_i, s_cyc_i, s_ack_o;
  logic [15:0] m_adr_o;
  logic [15:0] m_dat_i;
  logic        m_we_o;
  logic [1:0]  m_sel_o;
  logic        m_stb_o, m_cyc_o, m_ack_i;
  logic [2:0]  m_cti_o;
  logic        frame_req;
  logic [15:0] px_data;
  logic [3:0]  px_row;
  logic [4:0]  px_col;
  logic        px_last, px_valid, px_ready;

  // RAM model: zero-wait ack, data derived from address; one address can be made to never ack
  logic        hold_en;
  logic [15:0] hold_adr;
  assign m_dat_i = m_adr_o ^ 16'h5A5A;
  assign m_ack_i = m_stb_o & m_cyc_o & ~(hold_en & (m_adr_o == hold_adr));

  always #5 clk = ~clk;

  matrix_frame_fetch #(
    .ADDRESS_WIDTH(16), .DATA_WIDTH(16), .COLS(COLS), .ROWS(ROWS), .MAX_WAIT(8), .RESET_FRAME(0)
  ) dut (
    .clk(clk), .rst(rst),
    .s_adr_i(s_adr_i), .s_dat_i(s_dat_i), .s_dat_o(s_dat_o), .s_we_i(s_we_i),
    .s_stb_i(s_stb_i), .s_cyc_i(s_cyc_i), .s_ack_o(s_ack_o),
    .m_adr_o(m_adr_o), .m_dat_i(m_dat_i), .m_we_o(m_we_o), .m_sel_o(m_sel_o),
    .m_stb_o(m_stb_o), .m_cyc_o(m_cyc_o), .m_ack_i(m_ack_i), .m_cti_o(m_cti_o),
    .frame_req(frame_req),
    .px_data(px_data), .px_row(px_row), .px_col(px_col), .px_last(px_last),
    .px_valid(px_valid), .px_ready(px_ready)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] pix_adr(input logic [15:0] base, input int k);
    logic [3:0] r;
    logic [4:0] c;
    r = 4'(k / COLS);
    c = 5'(k % COLS);
    return base + {6'b0, r, c, 1'b0};
  endfunction

  task automatic wb_write(input logic [1:0] adr, input logic [15:0] dat);
    @(negedge clk);
    s_cyc_i = 1'b1; s_stb_i = 1'b1; s_we_i = 1'b1; s_adr_i = adr; s_dat_i = dat;
    @(posedge clk); #1;
    chk("wb_wr_ack", 32'(s_ack_o), 32'd1);
    @(negedge clk);
    s_cyc_i = 1'b0; s_stb_i = 1'b0; s_we_i = 1'b0;
  endtask

  task automatic wb_read(input logic [1:0] adr, output logic [15:0] dat);
    @(negedge clk);
    s_cyc_i = 1'b1; s_stb_i = 1'b1; s_we_i = 1'b0; s_adr_i = adr;
    @(posedge clk); #1;
    chk("wb_rd_ack", 32'(s_ack_o), 32'd1);
    dat = s_dat_o;
    @(negedge clk);
    s_cyc_i = 1'b0; s_stb_i = 1'b0;
  endtask

  // Runs one frame from a frame_req pulse, checking every request address and every pixel.
  // stall_at: pixel held with px_ready=0 for 10 cycles (optional FRAME_ADDR write first);
  // to_at: pixel whose read never acks; rst_at: pixel at which reset is asserted.
  task automatic run_frame(input string nm, input logic [15:0] base, input int stall_at,
                           input bit do_wr, input logic [15:0] wr_val,
                           input int to_at, input int rst_at);
    int n, pix, req, first_stb;
    bit prev_stb, done, aborted;
    logic [15:0] exp_d, held;
    n = 0; pix = 0; req = 0; first_stb = -1;
    prev_stb = 1'b0; done = 1'b0; aborted = 1'b0;
    hold_en  = (to_at >= 0);
    hold_adr = (to_at >= 0) ? pix_adr(base, to_at) : 16'h0;
    @(negedge clk); frame_req = 1'b1;
    @(negedge clk); frame_req = 1'b0;
    while (!done && n < 4000) begin
      if (m_stb_o && !prev_stb) begin
        if (first_stb < 0) first_stb = n;
        chk({nm, "_adr"}, 32'(m_adr_o), 32'(pix_adr(base, req)));
        req++;
      end
      prev_stb = m_stb_o;
      if (px_valid) begin
        exp_d = (pix == to_at) ? 16'h0 : (pix_adr(base, pix) ^ 16'h5A5A);
        chk({nm, "_data"}, 32'(px_data), 32'(exp_d));
        chk({nm, "_pos"}, 32'({px_row, px_col, px_last}),
            32'({4'(pix / COLS), 5'(pix % COLS), (pix == NPIX - 1)}));
        if (pix == rst_at) begin
          rst = 1'b1;
          #1;
          chk("rst_px_valid", 32'(px_valid), 32'd0);
          chk("rst_m_stb",    32'({m_stb_o, m_cyc_o}), 32'd0);
          chk("rst_px_data",  32'(px_data), 32'd0);
          chk("rst_px_pos",   32'({px_row, px_col, px_last}), 32'd0);
          chk("rst_m_adr",    32'(m_adr_o), 32'd0);
          @(negedge clk);
          rst = 1'b0;
          aborted = 1'b1;
          done = 1'b1;
        end else begin
          if (pix == stall_at) begin
            px_ready = 1'b0;
            held = px_data;
            if (do_wr) wb_write(2'd0, wr_val);
            repeat (10) begin
              @(negedge clk);
              chk("stall_valid", 32'(px_valid), 32'd1);
              chk("stall_data",  32'(px_data), 32'(held));
              chk("stall_stb",   32'(m_stb_o), 32'd0);
            end
            px_ready = 1'b1;
          end
          if (px_last) done = 1'b1;
          pix++;
        end
      end
      if (!done) begin
        @(negedge clk);
        n++;
      end
    end
    chk({nm, "_finished"}, 32'(done), 32'd1);
    if (!aborted) begin
      chk({nm, "_first_stb_lat"}, 32'(first_stb), 32'd2);
      chk({nm, "_npix"}, 32'(pix), 32'(NPIX));
      chk({nm, "_nreq"}, 32'(req), 32'(NPIX));
      repeat (3) @(negedge clk);
      chk({nm, "_idle"}, 32'({px_valid, m_stb_o, m_cyc_o}), 32'd0);
    end
    hold_en = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [15:0] rd;
    rst = 1'b1;
    s_adr_i = '0; s_dat_i = '0; s_we_i = 1'b0; s_stb_i = 1'b0; s_cyc_i = 1'b0;
    frame_req = 1'b0; px_ready = 1'b1; hold_en = 1'b0; hold_adr = '0;
    repeat (2) @(negedge clk);
    chk("reset_outs", 32'({px_valid, px_last, m_stb_o, m_cyc_o, s_ack_o}), 32'd0);
    chk("reset_px_data", 32'(px_data), 32'd0);
    chk("reset_consts", 32'({m_we_o, m_sel_o, m_cti_o}), 32'b0_11_000);
    rst = 1'b0;

    wb_read(2'd1, rd);  chk("status_reset", 32'(rd), 32'h0000);
    wb_read(2'd0, rd);  chk("faddr_reset",  32'(rd), 32'h0000);

    // Frame 1 at 0x0400; pixel (1,2) lands on 0x0444
    wb_write(2'd0, 16'h0400);
    wb_read(2'd1, rd);  chk("status_pending", 32'(rd), 32'h0001);
    wb_read(2'd0, rd);  chk("faddr_0400",     32'(rd), 32'h0400);
    wb_write(2'd1, 16'hFFFF);
    wb_read(2'd0, rd);  chk("status_wr_ignored", 32'(rd), 32'h0400);
    run_frame("f1", 16'h0400, -1, 1'b0, 16'h0, -1, -1);
    wb_read(2'd1, rd);  chk("status_after_f1", 32'(rd), 32'h01C0);

    // Frame 2: stall with a write of 0x0800 in the middle, base must not change
    run_frame("f2", 16'h0400, 50, 1'b1, 16'h0800, -1, -1);
    wb_read(2'd1, rd);  chk("status_after_f2", 32'(rd), 32'h01C1);
    wb_read(2'd0, rd);  chk("faddr_0800",      32'(rd), 32'h0800);

    // Frame 3 at 0x0800 with a read timeout at pixel (0,5)
    run_frame("f3", 16'h0800, -1, 1'b0, 16'h0, 5, -1);
    wb_read(2'd1, rd);  chk("status_err", 32'(rd), 32'h01C4);

    // Frame 4: reset at pixel (7,3)
    run_frame("f4", 16'h0800, -1, 1'b0, 16'h0, -1, 7 * COLS + 3);
    wb_read(2'd1, rd);  chk("status_after_rst", 32'(rd), 32'h0000);
    wb_read(2'd0, rd);  chk("faddr_after_rst",  32'(rd), 32'h0000);

    // Two writes between frames: last one wins, frame restarts at (0,0)
    wb_write(2'd0, 16'h1000);
    wb_write(2'd0, 16'h1200);
    wb_read(2'd0, rd);  chk("faddr_last_wins", 32'(rd), 32'h1200);
    run_frame("f5", 16'h1200, -1, 1'b0, 16'h0, -1, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
